esfa_cmd_sequencer: RTL
=======================

Name: esfa_cmd_sequencer

Overview:
Upstream command front-end for the ESFA memory array top-level.
- Accepts host commands over a valid/ready handshake.
- Expands each command into the selector phases the array needs: optional prep phases 5, 2, 6, then the main op.
- Drives the array's selector, handle, index and value inputs, and holds IDLE_SEL between phases.
- Captures the array's result bool and value, and returns them over a valid/ready response channel.

Parameters:
- SEL_W, 8, width of selector/op codes.
- DATA_W, 8, width of handle, index, value and result fields.
- PHASE_CYCLES, 2, cycles each phase holds its selector before the capture edge (min 1).
- IDLE_SEL, 8, selector code driven whenever no phase is active.

Ports:
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when valid&&ready
- cmd_op  in  SEL_W  main selector code
- cmd_prep  in  3  prep request; bit0=phase 5, bit1=phase 2, bit2=phase 6
- cmd_handle  in  DATA_W  queried handle
- cmd_index  in  DATA_W  new index
- cmd_value  in  DATA_W  new value
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when valid&&ready
- rsp_bool  out  1  captured result bool
- rsp_value  out  DATA_W  captured result value
- esfa_selector  out  SEL_W  to array selector
- esfa_queried_handle  out  DATA_W  to array
- esfa_new_index  out  DATA_W  to array
- esfa_new_value  out  DATA_W  to array
- esfa_result_bool  in  1  from array resultBool
- esfa_result_value  in  DATA_W  from array resultValue
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (reset=0, async) values:
  - state=IDLE, esfa_selector=IDLE_SEL.
  - All other data outputs 0; rsp_valid=0; cmd_ready=1 after deassertion.
- Reset mid-command aborts the command immediately; no response is produced.
- FSM states: IDLE, PREP, GAP, MAIN, RESP.
- IDLE: cmd_ready=1. On accept:
  - latch op/prep/handle/index/value into command regs.
  - drive handle/index/value outputs from those regs for the whole command.
  - go to PREP if cmd_prep!=0, else MAIN.
- PREP:
  - phases are issued in fixed order 5, 2, 6, skipping bits that are 0.
  - each phase drives its selector for PHASE_CYCLES cycles, then goes to GAP.
- GAP: one cycle of IDLE_SEL. Next state is the next pending prep phase, else MAIN.
- MAIN:
  - drives cmd_op for PHASE_CYCLES cycles.
  - on the final cycle's edge, registers esfa_result_bool/value into rsp_bool/rsp_value, sets rsp_valid=1 and goes to RESP.
  - selector returns to IDLE_SEL on that same edge.
- cmd_op==IDLE_SEL: MAIN is skipped and the response is bool=0, value=0. Prep phases still run.
- RESP: rsp_valid held with stable data until rsp_ready. On handshake, go to IDLE and drop rsp_valid.
  - rsp_ready may be high in advance: the handshake completes on the first RESP cycle.
- Latency, accept edge to rsp_valid high: PHASE_CYCLES + n_prep*(PHASE_CYCLES+1) cycles.
  - With no prep and PHASE_CYCLES=2, this is 2 cycles.
- A phase counter of width clog2(PHASE_CYCLES)+1 counts down and reloads on each phase entry.
- cmd_ready=0 in every non-IDLE state (unbuffered build). New commands are never accepted while rsp_valid is high.

Optional Feature:
- Macro: ESFA_SEQ_CMD_BUF_EN.
- Defined:
  - a 2-entry command FIFO sits before the FSM; cmd_ready = !fifo_full.
  - the FSM pops from the FIFO in IDLE.
  - a push and a pop in the same cycle are both allowed when the FIFO is full.
  - reset empties the FIFO.
- Undefined: direct single-command capture exactly as in Behaviour.

Decomposition:
- Shared package esfa_pkg holds:
  - selector constants: SEL_GIVEN_CODE=2, SEL_AVAIL_HANDLE=5, SEL_GIVEN_RANK=6, SEL_IDLE=8.
  - the state enum.
  - a command struct {op, prep, handle, index, value}.
- Natural sub-module: esfa_cmd_fifo, the 2-deep FIFO, instantiated only under ESFA_SEQ_CMD_BUF_EN.

Test Plan:
- Reset mid-MAIN: assert reset during a MAIN phase -> selector=8 and rsp_valid=0 immediately (async); cmd_ready=1 after release.
- Plain op: op=3, prep=0, handle=4, result model returns {1,0x2A} -> selector=3 for exactly 2 cycles, rsp_valid 2 cycles after accept, rsp={1,0x2A}.
- Full prep: prep=3'b111, op=4 -> selector sequence 5,5,8,2,2,8,6,6,8,4,4 then 8; rsp_valid 11 cycles after accept.
- Response backpressure: rsp_ready=0 for 5 cycles -> rsp stable, cmd_ready=0 throughout, selector=8; on rsp_ready=1 one handshake, then IDLE.
- Idle-op command: op=8, prep=3'b010 -> one selector-2 phase and one GAP, then rsp={0,0}; no cycle with an op selector.
- Buffered build (ESFA_SEQ_CMD_BUF_EN): offer 3 back-to-back commands while busy -> first two accepted, third stalls until a pop; responses return in order.

Source files
------------

// File: rtl/esfa_pkg.sv
// esfa_pkg: definitions shared by the ESFA command sequencer and its FIFO.
//   - selector codes the array understands (prep phases and idle)
//   - sequencer state enum
//   - command record layout {op, prep, handle, index, value} at default widths
//   - prep_sel(): selector for the highest-priority pending prep phase
package esfa_pkg;

  localparam logic [7:0] SEL_GIVEN_CODE   = 8'd2;
  localparam logic [7:0] SEL_AVAIL_HANDLE = 8'd5;
  localparam logic [7:0] SEL_GIVEN_RANK   = 8'd6;
  localparam logic [7:0] SEL_IDLE         = 8'd8;

  localparam int CMD_SEL_W  = 8;
  localparam int CMD_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_GAP  = 3'd2,
    ST_MAIN = 3'd3,
    ST_RESP = 3'd4
  } state_e;

  typedef struct packed {
    logic [CMD_SEL_W-1:0]  op;
    logic [2:0]            prep;
    logic [CMD_DATA_W-1:0] handle;
    logic [CMD_DATA_W-1:0] index;
    logic [CMD_DATA_W-1:0] value;
  } cmd_t;

  // Prep phases run in the fixed order 5, 2, 6 (prep bits 0, 1, 2), so the
  // lowest set pending bit is always the phase currently being issued.
  function automatic logic [7:0] prep_sel(input logic [2:0] pend);
    if (pend[0])      return SEL_AVAIL_HANDLE;
    else if (pend[1]) return SEL_GIVEN_CODE;
    else              return SEL_GIVEN_RANK;
  endfunction

endpackage

// File: rtl/esfa_cmd_fifo.sv
// esfa_cmd_fifo: 2-entry first-word-fall-through command FIFO.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset (empties FIFO)
//   push_i, wdata_i    write request and data (ignored when full unless popping)
//   pop_i              read request (ignored when empty)
//   rdata_o            head entry, valid whenever empty_o is low
//   full_o, empty_o    occupancy flags
module esfa_cmd_fifo #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_q;
  logic         rd_q;
  logic [1:0]   cnt_q;
  logic         do_push;
  logic         do_pop;

  assign empty_o = (cnt_q == 2'd0);
  assign full_o  = (cnt_q == 2'd2);
  assign rdata_o = mem_q[rd_q];

  // A push into a full FIFO is legal when the head leaves on the same edge.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (do_push) wr_q <= ~wr_q;
      if (do_pop)  rd_q <= ~rd_q;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage carries no reset; only the pointers and count define contents.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/esfa_cmd_sequencer.sv
// esfa_cmd_sequencer: host command front-end for the ESFA memory array.
// Expands each accepted command into optional prep phases (5, 2, 6) followed
// by the main op, drives the array inputs, captures the array result at the
// end of the main phase and returns it on a response channel.
// Build option: ESFA_SEQ_CMD_BUF_EN adds a 2-entry command FIFO in front of
// the FSM (cmd_ready = !fifo_full); without it, commands are captured
// directly in IDLE.
// Handshakes: a transfer occurs on a rising clk edge where valid && ready;
// valid never waits on ready, and offered data is held until the transfer.
// Ports:
//   clk, reset                   clock, asynchronous active-low reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_op/prep/handle/index/value  command fields
//   rsp_valid/rsp_ready          response handshake
//   rsp_bool, rsp_value          captured array result
//   esfa_selector, esfa_queried_handle, esfa_new_index, esfa_new_value
//                                drive the array
//   esfa_result_bool/value       array result inputs
//   busy                         high whenever the FSM is not IDLE
module esfa_cmd_sequencer
  import esfa_pkg::*;
#(
  parameter int SEL_W        = 8,
  parameter int DATA_W       = 8,
  parameter int PHASE_CYCLES = 2,
  parameter int IDLE_SEL     = int'(SEL_IDLE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [SEL_W-1:0]  cmd_op,
  input  logic [2:0]        cmd_prep,
  input  logic [DATA_W-1:0] cmd_handle,
  input  logic [DATA_W-1:0] cmd_index,
  input  logic [DATA_W-1:0] cmd_value,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_bool,
  output logic [DATA_W-1:0] rsp_value,
  output logic [SEL_W-1:0]  esfa_selector,
  output logic [DATA_W-1:0] esfa_queried_handle,
  output logic [DATA_W-1:0] esfa_new_index,
  output logic [DATA_W-1:0] esfa_new_value,
  input  logic              esfa_result_bool,
  input  logic [DATA_W-1:0] esfa_result_value,
  output logic              busy
);

  localparam int                CNT_W      = $clog2(PHASE_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD   = CNT_W'(PHASE_CYCLES - 1);
  localparam logic [SEL_W-1:0]  IDLE_SEL_V = SEL_W'(IDLE_SEL);
  localparam int                CMD_W      = SEL_W + 3 + 3 * DATA_W;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          pend_q, pend_d;
  logic [SEL_W-1:0]    op_q, op_d;
  logic [DATA_W-1:0]   handle_q, handle_d;
  logic [DATA_W-1:0]   index_q, index_d;
  logic [DATA_W-1:0]   value_q, value_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_bool_q, rsp_bool_d;
  logic [DATA_W-1:0]   rsp_value_q, rsp_value_d;

  // Command source seen by the FSM in IDLE: the port directly, or the FIFO head.
  logic                take;
  logic [SEL_W-1:0]    src_op;
  logic [2:0]          src_prep;
  logic [DATA_W-1:0]   src_handle;
  logic [DATA_W-1:0]   src_index;
  logic [DATA_W-1:0]   src_value;

`ifdef ESFA_SEQ_CMD_BUF_EN
  logic             fifo_full;
  logic             fifo_empty;
  logic [CMD_W-1:0] fifo_rdata;

  esfa_cmd_fifo #(.W(CMD_W)) u_cmd_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (cmd_valid),
    .wdata_i ({cmd_op, cmd_prep, cmd_handle, cmd_index, cmd_value}),
    .pop_i   (take),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign cmd_ready = !fifo_full;
  assign take      = (state_q == ST_IDLE) && !fifo_empty;
  assign {src_op, src_prep, src_handle, src_index, src_value} = fifo_rdata;
`else
  assign cmd_ready  = (state_q == ST_IDLE);
  assign take       = cmd_valid && (state_q == ST_IDLE);
  assign src_op     = cmd_op;
  assign src_prep   = cmd_prep;
  assign src_handle = cmd_handle;
  assign src_index  = cmd_index;
  assign src_value  = cmd_value;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pend_q      <= '0;
      op_q        <= IDLE_SEL_V;
      handle_q    <= '0;
      index_q     <= '0;
      value_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_bool_q  <= 1'b0;
      rsp_value_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      op_q        <= op_d;
      handle_q    <= handle_d;
      index_q     <= index_d;
      value_q     <= value_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_bool_q  <= rsp_bool_d;
      rsp_value_q <= rsp_value_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    op_d        = op_q;
    handle_d    = handle_q;
    index_d     = index_q;
    value_d     = value_q;
    rsp_valid_d = rsp_valid_q;
    rsp_bool_d  = rsp_bool_q;
    rsp_value_d = rsp_value_q;

    case (state_q)
      ST_IDLE: begin
        if (take) begin
          op_d     = src_op;
          pend_d   = src_prep;
          handle_d = src_handle;
          index_d  = src_index;
          value_d  = src_value;
          cnt_d    = CNT_LOAD;
          if (src_prep != 3'b000) begin
            state_d = ST_PREP;
          end else if (src_op == IDLE_SEL_V) begin
            // Idle op: nothing to run, answer {0,0} straight away.
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_bool_d  = 1'b0;
            rsp_value_d = '0;
          end else begin
            state_d = ST_MAIN;
          end
        end
      end

      ST_PREP: begin
        if (cnt_q == '0) begin
          pend_d  = pend_q & (pend_q - 3'd1);  // retire the phase just issued
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_GAP: begin
        cnt_d = CNT_LOAD;
        if (pend_q != 3'b000) begin
          state_d = ST_PREP;
        end else if (op_q == IDLE_SEL_V) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_bool_d  = 1'b0;
          rsp_value_d = '0;
        end else begin
          state_d = ST_MAIN;
        end
      end

      ST_MAIN: begin
        if (cnt_q == '0) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_bool_d  = esfa_result_bool;
          rsp_value_d = esfa_result_value;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    esfa_selector = IDLE_SEL_V;
    case (state_q)
      ST_PREP: esfa_selector = SEL_W'(prep_sel(pend_q));
      ST_MAIN: esfa_selector = op_q;
      default: esfa_selector = IDLE_SEL_V;
    endcase
  end

  assign esfa_queried_handle = handle_q;
  assign esfa_new_index      = index_q;
  assign esfa_new_value      = value_q;
  assign rsp_valid           = rsp_valid_q;
  assign rsp_bool            = rsp_bool_q;
  assign rsp_value           = rsp_value_q;
  assign busy                = (state_q != ST_IDLE);

endmodule
